mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// CPU-to-RAM handshake controller: latches one request, drives a strobed RAM access
// against an asynchronous MFC handshake, and reports completion/timeout.
module mem_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] MAR,
  output logic       enable,
  output logic       rnw,
  output logic [7:0] bus,
  input  logic [7:0] MBR,
  input  logic       MFC
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t        state_q, state_d;
  logic          mfc_meta_q, mfc_s_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          abort_q, abort_d;
  logic [7:0]    mar_q, mar_d, bus_q, bus_d, rdata_q, rdata_d;
  logic          rnw_q, rnw_d, enable_q, enable_d;
  logic          done_q, done_d, err_q, err_d, busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    mar_d    = mar_q;
    rnw_d    = rnw_q;
    bus_d    = bus_q;
    rdata_d  = rdata_q;
    enable_d = enable_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (req) begin
          mar_d   = addr;
          rnw_d   = ~wr;
          bus_d   = wr ? wdata : 8'h00;
          abort_d = 1'b0;
          state_d = SETUP;
        end
      end
      // A still-high MFC from a previous access must drop before a new strobe.
      SETUP: begin
        if (!mfc_s_q) begin
          enable_d = 1'b1;
          cnt_d    = '0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (mfc_s_q) begin
          enable_d = 1'b0;
          if (rnw_q) rdata_d = MBR;
          cnt_d    = '0;
          state_d  = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          enable_d = 1'b0;
          abort_d  = 1'b1;
          cnt_d    = '0;
          state_d  = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (!mfc_s_q) begin
          done_d  = 1'b1;
          err_d   = abort_q;
          abort_d = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          abort_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      mfc_meta_q <= 1'b0;
      mfc_s_q    <= 1'b0;
      cnt_q      <= '0;
      abort_q    <= 1'b0;
      mar_q      <= 8'h00;
      rnw_q      <= 1'b1;
      bus_q      <= 8'h00;
      rdata_q    <= 8'h00;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mfc_meta_q <= MFC;
      mfc_s_q    <= mfc_meta_q;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      mar_q      <= mar_d;
      rnw_q      <= rnw_d;
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
      enable_q   <= enable_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign MAR    = mar_q;
  assign enable = enable_q;
  assign rnw    = rnw_q;
  assign bus    = bus_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: an ideal/forced-MFC RAM environment plus a transaction-level
// reference model (latency, err, rdata, memory image) driven by directed and random steps.
module tb_mem_ctrl;
  logic       CLK = 1'b0;
  logic       RST, req, wr, MFC;
  logic [7:0] addr, wdata, rdata, MAR, bus, MBR;
  logic       busy, done, err, enable, rnw;

  mem_ctrl #(.TIMEOUT(32)) dut (
    .CLK(CLK), .RST(RST), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .MAR(MAR),
    .enable(enable), .rnw(rnw), .bus(bus), .MBR(MBR), .MFC(MFC)
  );

  always #5 CLK = ~CLK;

  // RAM environment: MFC rises the edge after enable is seen high, drops with enable.
  logic [7:0] ram [256];
  logic       ram_q;
  logic       ram_ready = 1'b0;
  logic       mfc_mode, mfc_const;
  assign MFC = mfc_mode ? mfc_const : (ram_q & enable);
  assign MBR = ram[MAR];

  always @(posedge CLK) begin
    ram_q <= enable;
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 35);
      ram_ready <= 1'b1;
    end else if (!mfc_mode && enable && !ram_q && !rnw) begin
      ram[MAR] <= bus;
    end
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ideal RAM; mode 1: MFC tied low; mode 2: MFC stuck high after the strobe.
  task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                         input int mode, input bit hold, input bit junk);
    int   exp_lat, exp_en, n, en_cnt;
    bit   exp_err, got, stable;
    case (mode)
      1:       begin exp_lat = 34; exp_en = 32; exp_err = 1'b1; end
      2:       begin exp_lat = 36; exp_en = 3;  exp_err = 1'b1; end
      default: begin exp_lat = 8;  exp_en = 4;  exp_err = 1'b0; end
    endcase
    if (!w && mode != 1) exp_rdata = ref_mem[a];
    if (w && mode == 0) ref_mem[a] = d;
    mfc_mode  = (mode != 0);
    mfc_const = 1'b0;
    req = 1'b1; wr = w; addr = a; wdata = d;
    step();
    chk("accept_busy", busy, 1);
    n = 0; en_cnt = 0; got = 0; stable = 1;
    while (!got && n < 100) begin
      if (MAR !== a || rnw !== ~w || bus !== (w ? d : 8'h00)) stable = 0;
      if (enable === 1'b1) en_cnt++;
      if (hold) begin
        req = 1'b1; wr = w; addr = a; wdata = d;
      end else if (junk && n < exp_lat - 1) begin
        req = 1'($urandom); wr = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      end else begin
        req = 1'b0;
      end
      if (mode == 2 && n == 1) mfc_const = 1'b1;
      step();
      n++;
      if (done === 1'b1) got = 1;
    end
    chk("done_seen", got, 1);
    chk("latency", n, exp_lat);
    chk("err", err, exp_err);
    chk("busy_at_done", busy, 0);
    chk("enable_cycles", en_cnt, exp_en);
    chk("held_MAR_rnw_bus", stable, 1);
    chk("rdata", rdata, exp_rdata);
    mfc_const = 1'b0;
    if (!hold) begin
      req = 1'b0;
      step();
      chk("done_one_cycle", done, 0);
      chk("no_dup_start", busy, 0);
    end
  endtask

  initial begin
    int   n;
    bit   got, guard_ok;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 35);
    exp_rdata = 8'h00;
    mfc_mode = 1'b1; mfc_const = 1'b0;
    RST = 1'b1; req = 1'b0; wr = 1'b0; addr = 8'h00; wdata = 8'h00;
    step(); step(); step();
    chk("rst_enable", enable, 0);
    chk("rst_rnw", rnw, 1);
    chk("rst_MAR", MAR, 8'h00);
    chk("rst_bus", bus, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_done_err_busy", {done, err, busy}, 3'b000);
    RST = 1'b0;
    step();

    run_txn(1'b0, 8'h01, 8'h00, 0, 1'b0, 1'b0);
    chk("read_01_is_48", rdata, 8'h48);
    run_txn(1'b1, 8'h0B, 8'h79, 0, 1'b0, 1'b1);
    run_txn(1'b0, 8'h0B, 8'h00, 0, 1'b0, 1'b0);
    chk("readback_0B", rdata, 8'h79);
    run_txn(1'b0, 8'h33, 8'h00, 1, 1'b0, 1'b1);
    run_txn(1'b0, 8'h44, 8'h00, 2, 1'b0, 1'b0);
    run_txn(1'b1, 8'h10, 8'hA5, 0, 1'b1, 1'b0);
    run_txn(1'b1, 8'h10, 8'hA5, 0, 1'b0, 1'b0);
    run_txn(1'b0, 8'h10, 8'h00, 0, 1'b0, 1'b0);

    // Reset in ACCESS with MFC held high, then a new request must wait in SETUP.
    mfc_mode = 1'b0;
    req = 1'b1; wr = 1'b0; addr = 8'h22;
    step();
    req = 1'b0;
    step();
    chk("pre_rst_enable", enable, 1);
    mfc_mode = 1'b1; mfc_const = 1'b1;
    RST = 1'b1; req = 1'b1; addr = 8'h55;
    step();
    chk("rst_abort_enable", enable, 0);
    chk("rst_abort_busy", busy, 0);
    chk("rst_over_req_MAR", MAR, 8'h00);
    chk("rst_abort_rdata", rdata, 8'h00);
    exp_rdata = 8'h00;
    RST = 1'b0; req = 1'b0;
    step(); step(); step();
    req = 1'b1; wr = 1'b0; addr = 8'h20;
    step();
    req = 1'b0;
    guard_ok = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (enable !== 1'b0 || busy !== 1'b1) guard_ok = 0;
    end
    chk("setup_guard", guard_ok, 1);
    mfc_mode = 1'b0;
    n = 0; got = 0;
    while (!got && n < 100) begin
      step();
      n++;
      if (done === 1'b1) got = 1;
    end
    exp_rdata = ref_mem[8'h20];
    chk("post_guard_latency", n, 10);
    chk("post_guard_err", err, 0);
    chk("post_guard_rdata", rdata, exp_rdata);
    step();

    for (int t = 0; t < 14; t++) begin
      run_txn(1'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 5) == 0) ? 1 : 0, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
